// File: rtl/bus_arbitrated_driver.sv
// CHANNELS registered sources share one tri-state bus through a round-robin arbiter.
// A programmable float gap between owners keeps two channels from ever driving together.
module bus_arbitrated_driver #(
    parameter int WIDTH      = 16,
    parameter int CHANNELS   = 4,
    parameter int TURNAROUND = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [CHANNELS-1:0]       req,
    output tri   [WIDTH-1:0]          y,
    output logic [CHANNELS-1:0]       grant,
    output logic                      busy
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] TURN_INIT = CNT_W'(TURNAROUND);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t              state_r, state_s, arb_state_s;
    logic [IDX_W-1:0]    owner_r, owner_s, arb_owner_s;
    logic [IDX_W-1:0]    last_owner_r, last_owner_s, arb_last_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [CHANNELS-1:0] grant_r, grant_s, arb_grant_s;
    logic                busy_r, busy_s;
    logic                arb_found_s;
    logic [IDX_W-1:0]    arb_idx_s;
    logic [WIDTH-1:0]    bus_data_s;
    logic [WIDTH-1:0]    data_r [CHANNELS];

    // First requester strictly after 'last', wrapping modulo CHANNELS.
    function automatic logic [IDX_W:0] rr_pick(input logic [CHANNELS-1:0] r,
                                               input logic [IDX_W-1:0]    last);
        logic             found;
        logic             hit;
        logic [IDX_W-1:0] idx;
        int               c;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            c     = int'(last) + i;
            c     = (c >= CHANNELS) ? (c - CHANNELS) : c;
            hit   = !found && r[IDX_W'(c)];
            idx   = hit ? IDX_W'(c) : idx;
            found = found | r[IDX_W'(c)];
        end
        return {found, idx};
    endfunction

    function automatic logic [CHANNELS-1:0] one_hot(input logic [IDX_W-1:0] idx);
        return {{(CHANNELS-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign {arb_found_s, arb_idx_s} = rr_pick(req, last_owner_r);

    // Outcome of an arbitration round, shared by IDLE, zero-gap release and end of TURN.
    always_comb begin
        arb_state_s = arb_found_s ? DRIVE : IDLE;
        arb_owner_s = arb_found_s ? arb_idx_s : owner_r;
        arb_last_s  = arb_found_s ? arb_idx_s : last_owner_r;
        arb_grant_s = arb_found_s ? one_hot(arb_idx_s) : {CHANNELS{1'b0}};
    end

    // Next-state and next-output logic of the ownership FSM.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        last_owner_s = last_owner_r;
        cnt_s        = cnt_r;
        grant_s      = {CHANNELS{1'b0}};
        busy_s       = 1'b0;
        case (state_r)
            IDLE: begin
                state_s      = arb_state_s;
                owner_s      = arb_owner_s;
                last_owner_s = arb_last_s;
                grant_s      = arb_grant_s;
            end
            DRIVE: begin
                if (req[owner_r]) begin
                    grant_s = one_hot(owner_r);
                end else if (TURNAROUND > 0) begin
                    state_s = TURN;
                    busy_s  = 1'b1;
                    cnt_s   = TURN_INIT;
                end else begin
                    state_s      = arb_state_s;
                    owner_s      = arb_owner_s;
                    last_owner_s = arb_last_s;
                    grant_s      = arb_grant_s;
                end
            end
            TURN: begin
                cnt_s = (cnt_r > 3'd0) ? (cnt_r - 3'd1) : 3'd0;
                if (cnt_r <= 3'd1) begin
                    state_s      = arb_state_s;
                    owner_s      = arb_owner_s;
                    last_owner_s = arb_last_s;
                    grant_s      = arb_grant_s;
                end else begin
                    busy_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 3'd0;
            end
        endcase
    end

    // FSM state register; reset clears grant at once so the bus floats without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            owner_r      <= '0;
            last_owner_r <= LAST_INIT;
            cnt_r        <= 3'd0;
            grant_r      <= {CHANNELS{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            last_owner_r <= last_owner_s;
            cnt_r        <= cnt_s;
            grant_r      <= grant_s;
            busy_r       <= busy_s;
        end
    end

    // Per-channel source registers, each with its own load strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                data_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (load[i]) begin
                    data_r[i] <= d[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // AND-OR select of the owning channel's register.
    always_comb begin
        bus_data_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            bus_data_s = bus_data_s | (data_r[k] & {WIDTH{grant_r[k]}});
        end
    end

    assign y     = (|grant_r) ? bus_data_s : {WIDTH{1'bz}};
    assign grant = grant_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_bus_arbitrated_driver.sv
// Bench for bus_arbitrated_driver: directed table, hand sequences and a random run against a model.
// Bus nets are pulled up, so a floating bus reads as all ones.
module tb_bus_arbitrated_driver;

    localparam int W = 16;
    localparam int C = 4;
    localparam int T = 1;
    localparam logic [W-1:0] FLOAT = 16'hFFFF;

    logic           clk = 1'b0;
    logic           reset;
    logic [C-1:0]   load, req;
    logic [C*W-1:0] d;
    tri1  [W-1:0]   y;
    logic [C-1:0]   grant;
    logic           busy;

    logic [1:0]     load2, req2;
    logic [2*W-1:0] d2;
    tri1  [W-1:0]   y2;
    logic [1:0]     grant2;
    logic           busy2;
    logic           busy2_seen;

    int errors = 0;
    int checks = 0;

    bus_arbitrated_driver #(.WIDTH(W), .CHANNELS(C), .TURNAROUND(T)) dut (
        .clk(clk), .reset(reset), .load(load), .d(d), .req(req),
        .y(y), .grant(grant), .busy(busy)
    );

    bus_arbitrated_driver #(.WIDTH(W), .CHANNELS(2), .TURNAROUND(0)) dut0 (
        .clk(clk), .reset(reset), .load(load2), .d(d2), .req(req2),
        .y(y2), .grant(grant2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy2 === 1'b1) busy2_seen = 1'b1;
    end

    typedef struct {
        bit             do_reset;
        logic [C-1:0]   load;
        logic [C*W-1:0] d;
        logic [C-1:0]   req;
        logic [C-1:0]   g;
        logic           b;
        logic [W-1:0]   y;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(bit rs, logic [C-1:0] ld, logic [C*W-1:0] dd, logic [C-1:0] rq,
                                logic [C-1:0] g, logic b, logic [W-1:0] yy);
        vec_t v;
        v.do_reset = rs; v.load = ld; v.d = dd; v.req = rq; v.g = g; v.b = b; v.y = yy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        load = '0; req = '0; d = '0; load2 = '0; req2 = '0; d2 = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Reference model: owner index (-1 = none), remaining float cycles, last owner.
    int           m_owner, m_gap, m_last;
    logic [W-1:0] m_reg [C];

    task automatic model_reset();
        m_owner = -1; m_gap = 0; m_last = C - 1;
        for (int i = 0; i < C; i++) m_reg[i] = '0;
    endtask

    task automatic model_arb(input logic [C-1:0] r);
        m_owner = -1;
        for (int i = 1; i <= C; i++) begin
            int c = (m_last + i) % C;
            if (m_owner < 0 && r[c]) m_owner = c;
        end
        if (m_owner >= 0) m_last = m_owner;
    endtask

    task automatic model_step(input logic [C-1:0] ld, input logic [C*W-1:0] dd, input logic [C-1:0] r);
        for (int i = 0; i < C; i++) if (ld[i]) m_reg[i] = dd[i*W +: W];
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1;
                m_gap   = T;
                if (m_gap == 0) model_arb(r);
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) model_arb(r);
        end else begin
            model_arb(r);
        end
    endtask

    initial begin
        logic [C-1:0] exp_g;
        logic [W-1:0] exp_y;

        tbl[0]  = mk(0, 4'b0100, {16'h0000, 16'hA5A5, 16'h0000, 16'h0000}, 4'b0000, 4'b0000, 1'b0, FLOAT);
        tbl[1]  = mk(0, 4'b0000, '0,                                       4'b0100, 4'b0100, 1'b0, 16'hA5A5);
        tbl[2]  = mk(0, 4'b0010, {16'h0000, 16'h0000, 16'h1234, 16'h0000}, 4'b0110, 4'b0100, 1'b0, 16'hA5A5);
        tbl[3]  = mk(0, 4'b0000, '0,                                       4'b0010, 4'b0000, 1'b1, FLOAT);
        tbl[4]  = mk(0, 4'b0000, '0,                                       4'b0010, 4'b0010, 1'b0, 16'h1234);
        tbl[5]  = mk(0, 4'b1010, {16'h7777, 16'h0000, 16'hBEEF, 16'h0000}, 4'b0010, 4'b0010, 1'b0, 16'hBEEF);
        tbl[6]  = mk(0, 4'b0000, '0,                                       4'b0000, 4'b0000, 1'b1, FLOAT);
        tbl[7]  = mk(0, 4'b0000, '0,                                       4'b0000, 4'b0000, 1'b0, FLOAT);
        tbl[8]  = mk(1, 4'b0000, '0,                                       4'b0101, 4'b0001, 1'b0, 16'h0000);
        tbl[9]  = mk(0, 4'b0000, '0,                                       4'b0100, 4'b0000, 1'b1, FLOAT);
        tbl[10] = mk(0, 4'b0000, '0,                                       4'b0101, 4'b0100, 1'b0, 16'h0000);
        tbl[11] = mk(0, 4'b0000, '0,                                       4'b0001, 4'b0000, 1'b1, FLOAT);
        tbl[12] = mk(0, 4'b0000, '0,                                       4'b0001, 4'b0001, 1'b0, 16'h0000);

        busy2_seen = 1'b0;
        load = '0; req = '0; d = '0; load2 = '0; req2 = '0; d2 = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        step();
        reset = 1'b0;
        chk("reset grant", grant, 4'b0000);
        chk("reset busy", busy, 1'b0);
        chk("reset y", y, FLOAT);

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].do_reset) apply_reset();
            load = tbl[i].load; d = tbl[i].d; req = tbl[i].req;
            step();
            chk($sformatf("row%0d grant", i), grant, tbl[i].g);
            chk($sformatf("row%0d busy", i), busy, tbl[i].b);
            chk($sformatf("row%0d y", i), y, tbl[i].y);
        end

        // Asynchronous reset while channel 0 drives.
        load = 4'b0001; d = {48'h0, 16'h00FF}; req = 4'b0001;
        step();
        chk("pre-reset y", y, 16'h00FF);
        load = '0;
        #2 reset = 1'b1;
        #1;
        chk("async reset y", y, FLOAT);
        chk("async reset grant", grant, 4'b0000);
        chk("async reset busy", busy, 1'b0);
        step();
        reset = 1'b0;
        req = 4'b0001;
        step();
        chk("post-reset grant", grant, 4'b0001);
        chk("post-reset y", y, 16'h0000);

        // Zero-turnaround, two-channel handover.
        req = '0;
        busy2_seen = 1'b0;
        load2 = 2'b11; d2 = {16'hCAFE, 16'h1111}; req2 = 2'b01;
        step();
        chk("t0 grant first", grant2, 2'b01);
        chk("t0 y first", y2, 16'h1111);
        load2 = 2'b00; req2 = 2'b11;
        step();
        chk("t0 grant hold", grant2, 2'b01);
        req2 = 2'b10;
        step();
        chk("t0 grant handover", grant2, 2'b10);
        chk("t0 busy handover", busy2, 1'b0);
        chk("t0 y handover", y2, 16'hCAFE);
        chk("t0 busy never set", busy2_seen, 1'b0);

        // Random traffic against the model.
        apply_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            load = C'($urandom_range(0, 15)) & C'($urandom_range(0, 15));
            d    = {$urandom, $urandom};
            for (int b = 0; b < C; b++) if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            model_step(load, d, req);
            step();
            exp_g = (m_owner >= 0) ? C'(1 << m_owner) : '0;
            exp_y = (m_owner >= 0) ? m_reg[m_owner] : FLOAT;
            chk($sformatf("rnd%0d grant", n), grant, exp_g);
            chk($sformatf("rnd%0d busy", n), busy, (m_owner < 0 && m_gap > 0) ? 1'b1 : 1'b0);
            chk($sformatf("rnd%0d y", n), y, exp_y);
            checks++;
            if ($countones(grant) > 1) begin
                errors++;
                $display("FAIL rnd%0d onehot: got %b required at most one bit", n, grant);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbitrated_driver.md
# bus_arbitrated_driver

Parametrised successor to the team's two-group tri-state bus buffer: CHANNELS independent registered sources, each WIDTH bits, share one tri-state bus through a round-robin arbiter. A mandatory turnaround gap separates successive drivers so two channels never drive the bus at once. It sits between register-file/peripheral sources and the shared internal bus, replacing hand-wired output-enable decoding.

## Interface
- WIDTH, 16, bits per channel and bus width.
- CHANNELS, 4, number of sources (2..8).
- TURNAROUND, 1, bus-float cycles between owners (0..7).

- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high.
- load  in  CHANNELS  per-channel latch strobe.
- d  in  CHANNELS*WIDTH  channel i data at d[i*WIDTH +: WIDTH].
- req  in  CHANNELS  request to own the bus; level, held for the whole ownership.
- y  out (tri)  WIDTH  shared bus; Z when no grant.
- grant  out  CHANNELS  one-hot owner, or all-zero.
- busy  out  1  high during turnaround.

## Operation
- Registers: posedge with load[i]=1 → reg[i] <= d slice i. Each channel loads independently, so several channels can load in the same cycle.
- y = reg[k] when grant[k]=1, else all-Z. Combinational from the registered grant and reg.
- FSM states IDLE, DRIVE, TURN; last_owner register holds the previous owner.
- IDLE: grant=0, busy=0.
  - If any req is set, grant the first requester searching upward from last_owner+1 (mod CHANNELS).
  - Set last_owner to that channel and go to DRIVE.
- DRIVE(k): stay while req[k]=1. No pre-emption; other requests wait.
  - If req[k]=0 and TURNAROUND>0: grant=0, busy=1, cnt=TURNAROUND, go to TURN.
  - If req[k]=0 and TURNAROUND=0: perform IDLE arbitration on the same edge, so the new owner takes over with no gap; with no requester, go to IDLE.
- TURN: grant=0, busy=1, cnt decrements each edge.
  - On the edge where cnt=1, perform IDLE arbitration: a requester present goes to DRIVE with busy=0; otherwise go to IDLE with busy=0.
- Reset values: reg[*]=0, grant=0, busy=0, y=Z, state IDLE, cnt=0, last_owner=CHANNELS-1 (channel 0 has first priority).
- Reset asserted mid-drive: y floats and grant clears immediately, without waiting for clk. Registers clear at the same moment.

## Timing
- req rising in IDLE, sampled at edge n → grant and y valid after edge n.
- load at edge n while channel owns the bus → y shows the new value after edge n.
- Release: req[k] low at edge n → bus floats after edge n for exactly TURNAROUND cycles. The next owner drives after edge n+TURNAROUND.
- grant is never two-hot.
- grant never goes from non-zero to a different non-zero value without a zero gap when TURNAROUND>0.
- Requests that appear during TURN are arbitrated at the final TURN edge; they do not add a cycle.
- A req pulse shorter than one cycle that misses an edge is ignored.

## Test plan
1. Reset, then load[2]=1 with d slice 2 = 16'hA5A5 at edge 1, req=0100 from edge 2 → after edge 2: grant=0100, y=16'hA5A5, busy=0. Before edge 1: y=16'hzzzz, grant=0000.
2. Channel 2 owns the bus and req[1] is held; req[2] is dropped at edge n → after edge n: grant=0000, busy=1, y=Z. After edge n+1: grant=0010, busy=0, y=reg[1].
3. Round-robin: req=0101 from IDLE after reset → grant=0001. Drop req[0] for one cycle, then re-raise it → after turnaround grant=0100, not 0001. Drop req[2] → after turnaround grant=0001.
4. Channel 1 owns the bus with y=16'h1234; load[1] at edge m with 16'hBEEF → after edge m y=16'hBEEF, grant unchanged. A simultaneous load[3] does not affect y.
5. Channel 0 owns the bus with y=16'h00FF; assert reset between edges → y=Z, grant=0000, busy=0 with no clock edge. After release, req[0] gives y=16'h0000.
6. Instance with TURNAROUND=0 and CHANNELS=2: channel 0 owns the bus; drop req[0] at edge n while req[1] is held → after edge n grant=10, busy never 1, y=reg[1].
